md_unit: RTL
============

# md_unit

Multi-cycle multiply/divide unit with HI/LO registers for the E stage of the 5-stage MIPS pipeline. It computes mult/multu/div/divu with a fixed latency and executes mthi/mtlo in one cycle. It drives `start`/`busy` back to the stall controller, which holds any HI/LO-class instruction in D while `start | busy` is high. mfhi/mflo read `HI`/`LO` combinationally in E.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage instruction is mult/multu/div/divu; a single-cycle pulse per instruction.
- `op`  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6..7=no-op.
- `we`  in  1  E-stage instruction is mthi/mtlo (qualifies `op` 4/5).
- `A`  in  32  forwarded rs value (FRSE-selected).
- `B`  in  32  forwarded rt value (FRTE-selected).
- `cancel`  in  1  present only with `MD_CANCEL_EN`; aborts the in-flight operation.
- `busy`  out  1  operation in flight.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
- States: IDLE, RUN. A 4-bit counter `cnt` and 64-bit result staging `{rhi, rlo}` back the RUN state.
- IDLE + `start` with `op` 0..3:
  - Compute the result from `A`/`B` into staging.
  - Load `cnt` with `MULT_CYCLES`-1 or `DIV_CYCLES`-1.
  - Go to RUN with `busy`=1.
- IDLE + `start` with `op` ≥ 4: ignored.
- RUN: `cnt` decrements each cycle. When `cnt`==0, on that edge:
  - `HI`←`rhi`, `LO`←`rlo`.
  - `busy`←0, go to IDLE.
- mthi/mtlo (`we`=1, `busy`=0, `start`=0): `HI`←`A` (op 4) or `LO`←`A` (op 5) on the next edge. Ignored while `busy`.
- `start` while `busy`: ignored (the stall controller guarantees this cannot occur). `start`+`we` in the same cycle: `start` wins.
- Arithmetic:
  - mult: signed 32×32→64, `{HI,LO}` = product.
  - multu: unsigned 32×32→64, `{HI,LO}` = product.
  - div/divu: `LO`=quotient truncated toward zero, `HI`=remainder with the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: `LO`=0x80000000, `HI`=0.
  - Divide by zero: full `DIV_CYCLES` latency, then `HI`/`LO` unchanged.
- Operands are captured at `start` only; later changes on `A`/`B` have no effect.
- Reset (asserted at any time, including mid-RUN): `busy`=0, `HI`=0, `LO`=0, `cnt`=0, state IDLE. The in-flight result is discarded.

## Timing
- `start` sampled at edge k: `busy`=1 after edge k through edge k+N-1; `HI`/`LO` update and `busy` falls at edge k+N (N = `MULT_CYCLES` or `DIV_CYCLES`).
- `busy` is registered; a dependent mfhi in D stalls on `start` in cycle k and on `busy` thereafter. It reads the new `HI` in the cycle after edge k+N.
- mthi/mtlo: 1-cycle latency, no `busy`.
- A new `start` is accepted in the cycle `busy` reads 0 (back-to-back with 0 idle cycles after completion).
- `HI`/`LO` are stable between updates; no output glitches from operand changes.

## Configuration
- `MD_CANCEL_EN` defined:
  - The `cancel` port exists. `cancel`=1 in RUN returns to IDLE on the next edge with `busy`=0 and `HI`/`LO` unchanged.
  - `cancel` in IDLE: no effect.
  - `cancel` and `start` in the same IDLE cycle: `start` is dropped.
  - Used for exception/flush of the E-stage instruction.
- Not defined: no `cancel` port. Every started operation runs to completion.

## Test plan
- Reset then mult A=0xFFFFFFFE(-2), B=3: `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9(-7), B=2: after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 gives LO=3, HI=1.
- mthi A=0x1234 then divu B=0: HI remains 0x1234, LO remains its prior value, `busy` high 10 cycles; div 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
- mult in flight; toggle `A`/`B` and pulse `start`/`we` at cycle 2: result reflects the original operands, extra requests ignored; next mult issued the cycle `busy` falls is accepted.
- Assert `reset` low at cycle 3 of a div: `busy`, HI, LO read 0 immediately (asynchronous); no update occurs at the original completion cycle.
- With `MD_CANCEL_EN`: `cancel` at cycle 2 of a mult: `busy`=0 next edge, HI/LO unchanged; without the macro the same sequence completes normally.

Source files
------------

// File: rtl/md_unit_if.sv
// Handshake and HI/LO bus between the E-stage pipeline and md_unit.
// The cancel signal exists only when MD_CANCEL_EN is defined.
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic        we;
  logic [31:0] A;
  logic [31:0] B;
`ifdef MD_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start,
    output op,
    output we,
    output A,
    output B,
`ifdef MD_CANCEL_EN
    output cancel,
`endif
    input  busy,
    input  HI,
    input  LO
  );

  modport slave (
    input  start,
    input  op,
    input  we,
    input  A,
    input  B,
`ifdef MD_CANCEL_EN
    input  cancel,
`endif
    output busy,
    output HI,
    output LO
  );
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit with HI/LO registers for the MIPS E stage.
// Define MD_CANCEL_EN to add a cancel input that aborts the in-flight operation.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rhi_q, rhi_d, rlo_q, rlo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        upd_q, upd_d;
  logic        cancel_req;

`ifdef MD_CANCEL_EN
  assign cancel_req = bus.cancel;
`else
  assign cancel_req = 1'b0;
`endif

  logic [63:0] prod_s, prod_u, result;
  logic [31:0] quo, rem;

  assign prod_s = $unsigned($signed({{32{bus.A[31]}}, bus.A}) *
                            $signed({{32{bus.B[31]}}, bus.B}));
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Signed overflow case is pinned explicitly rather than left to the divider.
  always_comb begin
    quo = '0;
    rem = '0;
    if (bus.B == 32'd0) begin
      quo = '0;
      rem = '0;
    end else if (bus.op[0]) begin
      quo = bus.A / bus.B;
      rem = bus.A % bus.B;
    end else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
      quo = 32'h8000_0000;
      rem = '0;
    end else begin
      quo = $unsigned($signed(bus.A) / $signed(bus.B));
      rem = $unsigned($signed(bus.A) % $signed(bus.B));
    end
  end

  always_comb begin
    if (bus.op[1]) result = {rem, quo};
    else           result = bus.op[0] ? prod_u : prod_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    upd_d   = upd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (!bus.op[2] && !cancel_req) begin
            {rhi_d, rlo_d} = result;
            cnt_d          = bus.op[1] ? DivLoad : MultLoad;
            // Divide by zero still takes full latency but leaves HI/LO alone.
            upd_d          = !(bus.op[1] && bus.B == 32'd0);
            state_d        = StRun;
          end
        end else if (bus.we) begin
          if (bus.op == 3'd4) hi_d = bus.A;
          if (bus.op == 3'd5) lo_d = bus.A;
        end
      end
      StRun: begin
        if (cancel_req) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          if (upd_q) begin
            hi_d = rhi_q;
            lo_d = rlo_q;
          end
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rhi_q   <= '0;
      rlo_q   <= '0;
      upd_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      upd_q   <= upd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
